// File: rtl/ins_seq.sv
// ins_seq: fetch/decode/execute sequencer for the 4-bit CPU.
// Owns the PC, the IMEM handshake, the instruction register and the retire count.
module ins_seq #(
  parameter int INS_W    = 11,
  parameter int PC_W     = 4,
  parameter int DEC_WAIT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [INS_W-1:0] imem_data_i,
  output logic [INS_W-1:0] ins_o,
  input  logic             dec_we_i,
  input  logic [PC_W-1:0]  dec_jmp_i,
  output logic             wb_en_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [7:0]       retired_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_e;

  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b011;
  localparam logic [7:0] TMO     = 8'(TIMEOUT);
  localparam logic [2:0] DLAST   = 3'(DEC_WAIT - 1);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic [7:0]       ret_q, ret_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [2:0]       dcnt_q, dcnt_d;
  logic [2:0]       op;
  logic             wb_en;

  assign op = ins_q[INS_W-1 -: 3];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ins_q   <= '0;
      ret_q   <= '0;
      tmo_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      ret_q   <= ret_d;
      tmo_q   <= tmo_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    ret_d   = ret_q;
    tmo_d   = tmo_q;
    dcnt_d  = dcnt_q;
    wb_en   = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
          tmo_d   = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          ins_d   = imem_data_i;
          dcnt_d  = '0;
          state_d = S_DECODE;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (dcnt_q == DLAST) state_d = S_EXEC;
        else dcnt_d = dcnt_q + 3'd1;
      end
      S_EXEC: begin
        ret_d   = ret_q + 8'd1;
        tmo_d   = '0;
        state_d = S_FETCH;
        unique case (1'b1)
          op == OP_JMP:  pc_d = dec_jmp_i;
          op == OP_HALT: state_d = S_HALT;
          default: begin
            wb_en = dec_we_i;
            pc_d  = pc_q + 1'b1;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe stays combinational so it can never outlive EXEC or a reset.
  assign wb_en_o     = wb_en;
  assign imem_req_o  = state_q == S_FETCH;
  assign imem_addr_o = pc_q;
  assign ins_o       = ins_q;
  assign busy_o      = state_q inside {S_FETCH, S_DECODE, S_EXEC};
  assign halted_o    = state_q == S_HALT;
  assign fault_o     = state_q == S_FAULT;
  assign retired_o   = ret_q;

endmodule

// File: tb/tb_ins_seq.sv
// tb_ins_seq: scoreboard bench for ins_seq with a program-level model.
// Memory model answers fetches with random latency; a monitor pops expectations.
module tb_ins_seq;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        req;
  logic [3:0]  addr;
  logic        ack = 0;
  logic [10:0] data = '0;
  logic [10:0] ins;
  logic        dec_we;
  logic [3:0]  dec_jmp;
  logic        wb, busy, halted, fault;
  logic [7:0]  retired;

  int checks = 0;
  int failures = 0;

  logic [10:0] mem [16];
  int delay_min = 0;
  int delay_max = 0;
  bit never_ack = 0;

  logic [3:0] addr_q [$];
  bit         wb_q [$];

  always #5 clk = ~clk;

  ins_seq #(.INS_W(11), .PC_W(4), .DEC_WAIT(1), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_data_i(data),
    .ins_o(ins), .dec_we_i(dec_we), .dec_jmp_i(dec_jmp),
    .wb_en_o(wb), .busy_o(busy), .halted_o(halted),
    .fault_o(fault), .retired_o(retired)
  );

  assign dec_we  = ins[4];
  assign dec_jmp = ins[3:0];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  int wcnt = 0;
  int dly = 0;
  always @(posedge clk) begin
    #1;
    if (req && !never_ack) begin
      if (wcnt >= dly) begin
        ack  = 1;
        data = mem[addr];
      end else begin
        ack = 0;
        wcnt++;
      end
    end else begin
      ack  = 0;
      wcnt = 0;
      dly  = $urandom_range(delay_max, delay_min);
    end
  end

  logic [7:0] ret_prev = 0;
  bit         wb_seen = 0;
  bit         prev_req = 0;
  logic [3:0] prev_addr = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ret_prev = 0;
      wb_seen  = 0;
      prev_req = 0;
    end else begin
      if (wb) wb_seen = 1;
      if (req && prev_req) chk("addr_stable", addr, prev_addr);
      prev_req  = req;
      prev_addr = addr;
      if (req && ack) begin
        checks++;
        if (addr_q.size() == 0) begin
          failures++;
          $display("FAIL fetch_unexpected act=%0h exp=none", addr);
        end else begin
          logic [3:0] e;
          e = addr_q.pop_front();
          if (addr !== e) begin
            failures++;
            $display("FAIL fetch_addr act=%0h exp=%0h", addr, e);
          end
        end
      end
      if (retired != ret_prev) begin
        checks++;
        if (wb_q.size() == 0) begin
          failures++;
          $display("FAIL retire_unexpected act=%0h exp=none", retired);
        end else begin
          bit e;
          e = wb_q.pop_front();
          if (wb_seen !== e) begin
            failures++;
            $display("FAIL wb_en act=%0b exp=%0b", wb_seen, e);
          end
        end
        wb_seen  = 0;
        ret_prev = retired;
      end
    end
  end

  task automatic model(input int limit, output int n, output bit h);
    logic [3:0]  pc;
    logic [10:0] i;
    pc = 0;
    n  = 0;
    h  = 0;
    while (n < limit && !h) begin
      i = mem[pc];
      addr_q.push_back(pc);
      n++;
      if (i[10:8] == 3'd4) begin
        wb_q.push_back(1'b0);
        pc = i[3:0];
      end else if (i[10:8] == 3'd3) begin
        wb_q.push_back(1'b0);
        h = 1;
      end else begin
        wb_q.push_back(i[4]);
        pc = pc + 4'd1;
      end
    end
    if (!h) addr_q.push_back(pc);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_outs", {req, busy, halted, fault, wb, retired, ins, addr}, 0);
    @(negedge clk);
    rst_n = 1;
    addr_q.delete();
    wb_q.delete();
  endtask

  task automatic run_prog(input int limit, input int dmin, input int dmax,
                          input int exp_cyc, input bit poke);
    int n;
    bit h;
    int cyc;
    logic [7:0] r0;
    delay_min = dmin;
    delay_max = dmax;
    never_ack = 0;
    r0 = retired;
    model(limit, n, h);
    pulse_start();
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = poke && (cyc == 7);
      if (h ? halted : (retired == 8'(r0 + n))) break;
    end
    start = 0;
    chk("run_bound", cyc < 5000, 1);
    if (exp_cyc > 0) chk("cycles", cyc, exp_cyc);
    @(negedge clk);
    chk("retired", retired, 8'(r0 + n));
    chk("wb_q_empty", wb_q.size(), 0);
    if (h) begin
      chk("halted", halted, 1);
      chk("busy", busy, 0);
      chk("addr_q_empty", addr_q.size(), 0);
    end else begin
      do_reset();
      chk("rst_retired", retired, 0);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic load_alu2_halt();
    clear_mem();
    mem[0] = 11'h010;
    mem[1] = 11'h010;
    mem[2] = 11'h300;
  endtask

  initial begin
    int cyc;
    logic [2:0] op;
    clear_mem();
    #12;
    chk("reset_outs", {req, busy, halted, fault, wb, retired, ins, addr}, 0);
    @(negedge clk);
    rst_n = 1;

    load_alu2_halt();
    run_prog(40, 0, 0, 9, 0);

    clear_mem();
    mem[0] = 11'h405;
    mem[5] = 11'h300;
    run_prog(40, 0, 0, 6, 0);

    load_alu2_halt();
    run_prog(40, 3, 3, 18, 0);

    never_ack = 1;
    pulse_start();
    cyc = 0;
    while (!fault && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("fault_cycles", cyc, 15);
    chk("fault_req", req, 0);
    chk("fault_busy", busy, 0);
    chk("fault_ins", ins, 11'h300);
    clear_mem();
    mem[0] = 11'h300;
    run_prog(40, 0, 0, 3, 0);
    chk("fault_cleared", fault, 0);

    for (int i = 0; i < 16; i++) begin
      do op = 3'($urandom); while (op == 3'd3 || op == 3'd4);
      mem[i] = {op, 8'($urandom)};
    end
    run_prog(16, 0, 2, 0, 1);

    clear_mem();
    mem[0] = 11'h010;
    delay_min = 0;
    delay_max = 0;
    addr_q.push_back(4'd0);
    pulse_start();
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_dec", {req, busy, wb, retired, ins}, 0);
    chk("rst_dec_q", addr_q.size(), 0);
    @(negedge clk);
    rst_n = 1;
    addr_q.push_back(4'd0);
    pulse_start();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_exec", {req, busy, wb, retired, ins}, 0);
    chk("rst_exec_q", addr_q.size(), 0);
    @(negedge clk);
    rst_n = 1;
    wb_q.delete();
    load_alu2_halt();
    run_prog(40, 0, 0, 9, 0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = 11'($urandom);
      run_prog(40, 0, 3, 0, k[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
